// File: rtl/audio_i2s_rx_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_rx_pkg
// Brief    : Shared definitions for the I2S capture peripheral: Wishbone
//            register addresses, CSR bit positions and deserialiser states.
// Revision : 1.0 - initial release
// ============================================================================
package audio_i2s_rx_pkg;

  // Register map (word addresses on wb_addr)
  localparam logic [1:0] C_ADDR_CSR  = 2'd0;
  localparam logic [1:0] C_ADDR_DATA = 2'd1;
  localparam logic [1:0] C_ADDR_RATE = 2'd2;
  localparam logic [1:0] C_ADDR_RSVD = 2'd3;

  // CSR bit positions
  localparam int C_CSR_ENABLE = 0;
  localparam int C_CSR_FLUSH  = 1;
  localparam int C_CSR_OVF    = 2;
  localparam int C_CSR_EMPTY  = 3;
  localparam int C_CSR_FULL   = 4;
  localparam int C_CSR_LEVEL  = 16;

  // Deserialiser frame-tracking states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_LEFT  = 2'd2,
    ST_RIGHT = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_i2s_rx_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_rx_wb_if
// Brief    : Wishbone slave bus bundle for the I2S capture peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface audio_i2s_rx_wb_if;
  logic [1:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;

  modport master (
    output wb_addr, wb_wdata, wb_we, wb_cyc,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_wdata, wb_we, wb_cyc,
    output wb_rdata, wb_ack
  );
endinterface
`default_nettype wire

// File: rtl/audio_i2s_rx_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : audio_rx_fifo
// Brief    : Synchronous 32-bit stereo frame FIFO, depth 2^AW, with flush,
//            level, full/empty and a dropped-push (overflow) pulse.
// Revision : 1.0 - initial release
// ============================================================================
module audio_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [31:0]   o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow
);
  localparam int          C_DEPTH      = 1 << AW;
  localparam logic [AW:0] C_FULL_LEVEL = {1'b1, {AW{1'b0}}};

  logic [31:0]   r_mem [C_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign w_full  = (r_level == C_FULL_LEVEL);
  assign w_empty = (r_level == '0);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // alongside a pop. Flush wins over both and silently drops the push.
  assign w_pop_ok   = i_pop & ~w_empty & ~i_flush;
  assign w_push_ok  = i_push & ~i_flush & (~w_full | w_pop_ok);
  assign o_overflow = i_push & ~i_flush & w_full & ~w_pop_ok;

  assign o_data  = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;

  // Pointer and level bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/audio_i2s_rx_wb.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_rx_wb
// Brief    : I2S stereo capture peripheral with Wishbone slave interface.
//            Synchronises async I2S pins, deserialises left/right words into
//            a frame FIFO drained by firmware through the DATA register.
//            Optional USB SOF frame-rate counter: AUDIO_RX_SOF_RATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_rx_wb #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_sck,
  input  logic              i2s_ws,
  input  logic              i2s_sd,
  audio_i2s_rx_wb_if.slave  wb,
  input  logic              usb_sof,
  output logic              irq
);
  import audio_i2s_rx_pkg::*;

  localparam logic [4:0]         C_IDX_SAT = 5'(DATA_W);
  localparam logic [FIFO_AW:0]   C_HALF    = (FIFO_AW+1)'(1 << (FIFO_AW - 1));

  // Synchroniser stages
  logic r_sck_s1, r_sck_s2, r_sck_s3;
  logic r_ws_s1, r_ws_s2;
  logic r_sd_s1, r_sd_s2;
  logic w_sck_rise;

  // Deserialiser
  logic       r_ws_last;
  logic [4:0] r_bit_idx;
  logic [15:0] r_left;
  logic [15:0] r_right;
  logic       w_ws_change;
  logic       w_bit_store;
  logic [15:0] w_bit_mask;
  logic [15:0] w_word_base;
  logic [15:0] w_word_next;
  rx_state_t  r_state;
  logic       r_push;

  // Register file / bus
  logic        r_enable;
  logic        r_overflow;
  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_irq;
  logic        w_access;
  logic        w_csr_wr;
  logic        w_flush;
  logic        w_pop;
  logic [31:0] w_csr_rd;
  logic [31:0] w_rate;

  // FIFO
  logic             w_fifo_push;
  logic [31:0]      w_fifo_data;
  logic [FIFO_AW:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_fifo_ovf;

  // Two-flop synchronisers; sck gets a third stage for rising-edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sck_s1 <= 1'b0; r_sck_s2 <= 1'b0; r_sck_s3 <= 1'b0;
      r_ws_s1  <= 1'b0; r_ws_s2  <= 1'b0;
      r_sd_s1  <= 1'b0; r_sd_s2  <= 1'b0;
    end else begin
      r_sck_s1 <= i2s_sck; r_sck_s2 <= r_sck_s1; r_sck_s3 <= r_sck_s2;
      r_ws_s1  <= i2s_ws;  r_ws_s2  <= r_ws_s1;
      r_sd_s1  <= i2s_sd;  r_sd_s2  <= r_sd_s1;
    end
  end

  assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
  assign w_ws_change = w_sck_rise & (r_ws_s2 ^ r_ws_last);

  // The bit sampled on the WS-change edge is still the LSB of the old
  // channel, so every bit goes to the channel selected by the previous WS.
  assign w_bit_store = (r_bit_idx < C_IDX_SAT);
  assign w_bit_mask  = 16'h8000 >> r_bit_idx;
  assign w_word_base = (r_bit_idx == 5'd0) ? 16'h0000 : (r_ws_last ? r_right : r_left);
  assign w_word_next = w_word_base | (r_sd_s2 ? w_bit_mask : 16'h0000);

  // Shift serial data MSB-first into the active channel word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ws_last <= 1'b0;
      r_bit_idx <= C_IDX_SAT;
      r_left    <= '0;
      r_right   <= '0;
    end else if (w_sck_rise) begin
      r_ws_last <= r_ws_s2;
      if (w_bit_store) begin
        if (r_ws_last) r_right <= w_word_next;
        else           r_left  <= w_word_next;
      end
      if (w_ws_change)      r_bit_idx <= 5'd0;
      else if (w_bit_store) r_bit_idx <= r_bit_idx + 5'd1;
    end
  end

  // Frame-tracking FSM; requests a push one clk after the right word closes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_push  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (!r_enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:  r_state <= ST_SYNC;
          ST_SYNC:  if (w_ws_change && !r_ws_s2) r_state <= ST_LEFT;
          ST_LEFT:  if (w_ws_change && r_ws_s2)  r_state <= ST_RIGHT;
          ST_RIGHT: if (w_ws_change && !r_ws_s2) begin
                      r_push  <= 1'b1;
                      r_state <= ST_LEFT;
                    end
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // A disable landing between frame close and push still discards the frame
  assign w_fifo_push = r_push & r_enable;

  audio_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_fifo_push),
    .i_data     ({r_right, r_left}),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_data     (w_fifo_data),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (w_fifo_ovf)
  );

  // Side effects happen on the edge that raises ack, so rdata and the pop
  // belong to the same access.
  assign w_access = wb.wb_cyc & ~r_ack;
  assign w_csr_wr = w_access & wb.wb_we & (wb.wb_addr == C_ADDR_CSR);
  assign w_flush  = w_csr_wr & wb.wb_wdata[C_CSR_FLUSH];
  assign w_pop    = w_access & ~wb.wb_we & (wb.wb_addr == C_ADDR_DATA);

  // CSR read image
  always_comb begin
    w_csr_rd = '0;
    w_csr_rd[C_CSR_ENABLE] = r_enable;
    w_csr_rd[C_CSR_OVF]    = r_overflow;
    w_csr_rd[C_CSR_EMPTY]  = w_empty;
    w_csr_rd[C_CSR_FULL]   = w_full;
    w_csr_rd[C_CSR_LEVEL +: FIFO_AW+1] = w_level;
  end

  // Wishbone acknowledge, read mux and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_ack <= w_access;
      r_irq <= (w_level >= C_HALF);
      if (w_access && !wb.wb_we) begin
        case (wb.wb_addr)
          C_ADDR_CSR:  r_rdata <= w_csr_rd;
          C_ADDR_DATA: r_rdata <= w_fifo_data;
          C_ADDR_RATE: r_rdata <= w_rate;
          C_ADDR_RSVD: r_rdata <= '0;
          default:     r_rdata <= '0;
        endcase
      end else begin
        r_rdata <= '0;
      end
      if (w_csr_wr) r_enable <= wb.wb_wdata[C_CSR_ENABLE];
      if (w_fifo_ovf)
        r_overflow <= 1'b1;
      else if (w_csr_wr && wb.wb_wdata[C_CSR_OVF])
        r_overflow <= 1'b0;
    end
  end

  assign wb.wb_ack   = r_ack;
  assign wb.wb_rdata = r_rdata;
  assign irq         = r_irq;

`ifdef AUDIO_RX_SOF_RATE_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_rate;
  logic        w_unused;

  // Frames per SOF period; a push coinciding with SOF counts toward the
  // period being closed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_rate      <= '0;
    end else if (usb_sof) begin
      r_rate      <= r_frame_cnt + 16'(w_fifo_push);
      r_frame_cnt <= '0;
    end else if (w_fifo_push) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign w_rate   = {16'h0000, r_rate};
  assign w_unused = &{1'b0, wb.wb_wdata[31:3]};
`else
  logic w_unused;
  assign w_rate   = '0;
  assign w_unused = &{1'b0, wb.wb_wdata[31:3], usb_sof};
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_rx_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_i2s_rx_wb
// Brief    : Directed self-checking bench for audio_i2s_rx_wb; expected
//            frames are queued as they are sent and popped on DATA reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_rx_wb;
  import audio_i2s_rx_pkg::*;

  localparam int HALF = 4;  // sck = clk/8

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i2s_sck = 1'b1;
  logic i2s_ws = 1'b0;
  logic i2s_sd = 1'b0;
  logic usb_sof = 1'b0;
  logic irq;

  audio_i2s_rx_wb_if bus();

  audio_i2s_rx_wb #(.DATA_W(16), .FIFO_AW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i2s_sck (i2s_sck),
    .i2s_ws  (i2s_ws),
    .i2s_sd  (i2s_sd),
    .wb      (bus),
    .usb_sof (usb_sof),
    .irq     (irq)
  );

  always #21 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; ack must be low when cyc rises and high one cycle later
  task automatic wb_xfer(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    @(negedge clk);
    bus.wb_addr  = addr;
    bus.wb_we    = we;
    bus.wb_wdata = wdata;
    bus.wb_cyc   = 1'b1;
    check("ack_before", {31'b0, bus.wb_ack}, 32'd0);
    @(negedge clk);
    check("ack_after_1", {31'b0, bus.wb_ack}, 32'd1);
    rdata = bus.wb_rdata;
    bus.wb_cyc = 1'b0;
    bus.wb_we  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    wb_xfer(1'b1, addr, data, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, addr, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp;
    exp = (sb.size() > 0) ? sb.pop_front() : 32'h0;
    wb_read_check(tag, C_ADDR_DATA, exp);
  endtask

  // One sck period: data/ws change while sck low, DUT samples on the rise
  task automatic i2s_period(input logic ws, input logic sd);
    i2s_sck = 1'b0;
    i2s_ws  = ws;
    i2s_sd  = sd;
    repeat (HALF) @(negedge clk);
    i2s_sck = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Periods 0..15 carry left MSB..LSB, 16..31 right; WS leads by one bit
  task automatic send_bits(input logic [15:0] l, input logic [15:0] r, input int from, input int to);
    for (int p = from; p <= to; p++) begin
      if (p < 16) i2s_period(p == 15, l[15-p]);
      else        i2s_period(p != 31, r[31-p]);
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_bits(l, r, 0, 31);
  endtask

  // Tail of a right word followed by the WS 1->0 edge that opens a left word
  task automatic preamble();
    i2s_period(1'b1, 1'b0);
    i2s_period(1'b1, 1'b1);
    i2s_period(1'b0, 1'b1);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  task automatic sof_pulse();
    @(negedge clk);
    usb_sof = 1'b1;
    @(negedge clk);
    usb_sof = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l, r;
    bus.wb_addr = '0; bus.wb_wdata = '0; bus.wb_we = 1'b0; bus.wb_cyc = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("irq_reset", {31'b0, irq}, 32'd0);
    wb_read_check("csr_reset", C_ADDR_CSR, 32'h0000_0008);
    read_data("data_empty_reset");
    wb_read_check("rate_reset", C_ADDR_RATE, 32'h0);

    // Single frame
    wb_write(C_ADDR_CSR, 32'h1);
    preamble();
    send_frame(16'h1234, 16'hABCD);
    sb.push_back(32'hABCD_1234);
    settle();
    wb_read_check("csr_level1", C_ADDR_CSR, 32'h0001_0001);
    read_data("data_frame1");
    wb_read_check("csr_level0", C_ADDR_CSR, 32'h0000_0009);
    read_data("data_empty_again");

    // Enable mid-right-channel: the partial frame must be discarded
    wb_write(C_ADDR_CSR, 32'h0);
    repeat (5) i2s_period(1'b0, 1'b1);
    repeat (3) i2s_period(1'b1, 1'b1);
    wb_write(C_ADDR_CSR, 32'h1);
    repeat (4) i2s_period(1'b1, 1'b0);
    i2s_period(1'b0, 1'b1);
    settle();
    wb_read_check("csr_partial_dropped", C_ADDR_CSR, 32'h0000_0009);
    send_frame(16'h5A01, 16'hC3A0);
    sb.push_back(32'hC3A0_5A01);
    settle();
    wb_read_check("csr_only_a", C_ADDR_CSR, 32'h0001_0001);
    read_data("data_frame_a");
    send_frame(16'h0F0F, 16'h8001);
    sb.push_back(32'h8001_0F0F);
    settle();
    read_data("data_frame_b");

    // Overflow: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      l = 16'h1000 + 16'(i);
      r = 16'hF000 - 16'(i * 3);
      send_frame(l, r);
      if (i < 16) sb.push_back({r, l});
    end
    settle();
    wb_read_check("csr_full_ovf", C_ADDR_CSR, 32'h0010_0015);
    check("irq_full", {31'b0, irq}, 32'd1);
    wb_write(C_ADDR_CSR, 32'h5);
    wb_read_check("csr_ovf_cleared", C_ADDR_CSR, 32'h0010_0011);
    for (int k = 0; k < 16; k++) begin
      read_data("data_drain");
      repeat (2) @(negedge clk);
      check("irq_drain", {31'b0, irq}, ((15 - k) >= 8) ? 32'd1 : 32'd0);
    end
    wb_read_check("csr_drained", C_ADDR_CSR, 32'h0000_0009);

    // Disable and re-enable mid-left: that frame is lost, the next is kept
    send_bits(16'hDEAD, 16'hBEEF, 0, 7);
    wb_write(C_ADDR_CSR, 32'h0);
    wb_write(C_ADDR_CSR, 32'h1);
    send_bits(16'hDEAD, 16'hBEEF, 8, 31);
    send_frame(16'h2468, 16'h1357);
    sb.push_back(32'h1357_2468);
    settle();
    wb_read_check("csr_after_reenable", C_ADDR_CSR, 32'h0001_0001);
    read_data("data_after_reenable");
    read_data("data_empty_reenable");

    // Reset mid-left
    send_bits(16'h7777, 16'h6666, 0, 7);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_read_check("csr_midframe_reset", C_ADDR_CSR, 32'h0000_0008);
    wb_write(C_ADDR_CSR, 32'h1);
    send_bits(16'h7777, 16'h6666, 8, 31);
    send_frame(16'h4321, 16'h8765);
    sb.push_back(32'h8765_4321);
    settle();
    read_data("data_after_reset");
    read_data("data_empty_reset2");

    // Rate: 48 frames between two SOF pulses
    sof_pulse();
    for (int i = 0; i < 48; i++) send_frame(16'(i), 16'(i + 100));
    settle();
    sof_pulse();
`ifdef AUDIO_RX_SOF_RATE_EN
    wb_read_check("rate_48", C_ADDR_RATE, 32'd48);
`else
    wb_read_check("rate_off", C_ADDR_RATE, 32'd0);
`endif
    wb_read_check("reserved_zero", C_ADDR_RSVD, 32'h0);
    wb_write(C_ADDR_CSR, 32'h3);
    wb_read_check("csr_flushed", C_ADDR_CSR, 32'h0000_000D);
    check("irq_flushed", {31'b0, irq}, 32'd0);
    wb_write(C_ADDR_CSR, 32'h5);
    wb_read_check("csr_final", C_ADDR_CSR, 32'h0000_0009);
    read_data("data_empty_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
